// File: rtl/multicycle_pkg.sv
// ============================================================================
// multicycle_pkg
// State encodings, opcodes, ALU/mux select codes and per-state control decode
// for the multi-cycle MIPS sequencer. Honours ILLEGAL_OPCODE_TRAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , S_HALT   = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FETCH's MemReady-gated PCWrite/IRWrite are added outside this struct.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic       halted;
`endif
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADDR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_HALT: begin
        c.halted = 1'b1;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/retire_counter.sv
// ============================================================================
// retire_counter
// Wrapping retired-instruction counter with synchronous active-high clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control
// Registered multi-cycle control FSM for the MIPS datapath with a MemReady
// handshake and retired-instruction counter. ILLEGAL_OPCODE_TRAP_EN adds HALT.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
`ifdef ILLEGAL_OPCODE_TRAP_EN
  , output logic           Halted
`endif
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_d;
  logic   retire;
  logic   fetch_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef ILLEGAL_OPCODE_TRAP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADDR:  state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_RTYPEWB;
      S_ADDIEX:   state_d = S_ADDIWB;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
    // Outputs are registered from the next state so they line up with State.
    ctrl_d = decode_ctrl(Reset ? S_FETCH : state_d);
  end

  always_comb begin
    case (state_q)
      S_MEMWB, S_RTYPEWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
      S_MEMWRITE: retire = MemReady;
      default:    retire = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
    ctrl_q <= ctrl_d;
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (retire),
    .count (InstrCount)
  );

  assign fetch_ready = (state_q == S_FETCH) && MemReady;

  assign PCWrite     = ctrl_q.pc_write | fetch_ready;
  assign IRWrite     = fetch_ready;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemToReg    = ctrl_q.mem_to_reg;
  assign RegDst      = ctrl_q.reg_dst;
  assign RegWrite    = ctrl_q.reg_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign PCSource    = ctrl_q.pc_source;
  assign State       = state_q;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  assign Halted      = ctrl_q.halted;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control
// Directed bench for multicycle_control; a 3-bit counter makes wrap reachable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  localparam int CNT_W = 3;

  logic             Clock;
  logic             Reset;
  logic [5:0]       Opcode;
  logic             MemReady;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstrCount;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic             Halted;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Opcode      (Opcode),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemToReg    (MemToReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .State       (State),
    .InstrCount  (InstrCount)
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , .Halted    (Halted)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; MemReady = 1'b1; Opcode = 6'b000000;
    step(); step();
    Reset = 1'b0;
    chk("reset_state", State, 0);
    chk("reset_count", InstrCount, 0);
    chk("reset_memread", MemRead, 1);
    chk("reset_pcwrite", PCWrite, 1);
    chk("reset_irwrite", IRWrite, 1);
    chk("fetch_srcb", ALUSrcB, 2'b01);

    // FETCH stall: Mealy enables drop and state holds
    MemReady = 1'b0;
    #1;
    chk("stall_pcwrite", PCWrite, 0);
    chk("stall_irwrite", IRWrite, 0);
    step();
    chk("stall_state", State, 0);
    MemReady = 1'b1;

    // lw
    Opcode = 6'b100011;
    step(); chk("lw_s1", State, 1); chk("lw_dec_srcb", ALUSrcB, 2'b11);
    step(); chk("lw_s2", State, 2); chk("lw_srca", ALUSrcA, 1); chk("lw_srcb", ALUSrcB, 2'b10);
    step(); chk("lw_s3", State, 3); chk("lw_iord", IorD, 1); chk("lw_rd_mr", MemRead, 1);
    chk("lw_s3_regwrite", RegWrite, 0);
    step(); chk("lw_s4", State, 4); chk("lw_regwrite", RegWrite, 1);
    chk("lw_memtoreg", MemToReg, 1); chk("lw_regdst", RegDst, 0);
    step(); chk("lw_s0", State, 0); chk("lw_count", InstrCount, 1);
    chk("lw_s0_regwrite", RegWrite, 0);

    // sw with three wait cycles in MEMWRITE
    Opcode = 6'b101011;
    step(); chk("sw_s1", State, 1);
    step(); chk("sw_s2", State, 2);
    MemReady = 1'b0;
    step(); chk("sw_w1_state", State, 5); chk("sw_w1_mw", MemWrite, 1);
    step(); chk("sw_w2_mw", MemWrite, 1);
    step(); chk("sw_w3_state", State, 5); chk("sw_w3_mw", MemWrite, 1);
    chk("sw_w3_count", InstrCount, 1);
    MemReady = 1'b1;
    #1;
    chk("sw_w4_mw", MemWrite, 1);
    step(); chk("sw_done_state", State, 0); chk("sw_count", InstrCount, 2);
    chk("sw_done_mw", MemWrite, 0);

    // beq
    Opcode = 6'b000100;
    step(); chk("beq_s1", State, 1);
    step(); chk("beq_s8", State, 8); chk("beq_pwc", PCWriteCond, 1);
    chk("beq_pcsrc", PCSource, 2'b01); chk("beq_aluop", ALUOp, 2'b01);
    chk("beq_srcb", ALUSrcB, 2'b00);
    step(); chk("beq_s0", State, 0); chk("beq_count", InstrCount, 3);

    // j
    Opcode = 6'b000010;
    step(); step(); chk("j_s9", State, 9); chk("j_pcwrite", PCWrite, 1);
    chk("j_pcsrc", PCSource, 2'b10);
    step(); chk("j_s0", State, 0); chk("j_count", InstrCount, 4);

    // R-type
    Opcode = 6'b000000;
    step(); step(); chk("r_s6", State, 6); chk("r_aluop", ALUOp, 2'b10);
    step(); chk("r_s7", State, 7); chk("r_regdst", RegDst, 1); chk("r_regwrite", RegWrite, 1);
    chk("r_memtoreg", MemToReg, 0);
    step(); chk("r_s0", State, 0); chk("r_count", InstrCount, 5);

    // addi
    Opcode = 6'b001000;
    step(); step(); chk("addi_s10", State, 10); chk("addi_srcb", ALUSrcB, 2'b10);
    step(); chk("addi_s11", State, 11); chk("addi_regwrite", RegWrite, 1);
    chk("addi_regdst", RegDst, 0);
    step(); chk("addi_s0", State, 0); chk("addi_count", InstrCount, 6);

    // two more jumps: 6 -> 7 (all ones) -> 0 (wrap)
    Opcode = 6'b000010;
    step(); step(); step(); chk("ones_count", InstrCount, 7);
    step(); step(); step(); chk("wrap_count", InstrCount, 0);

    // illegal opcode
    Opcode = 6'b111111;
    step(); chk("ill_s1", State, 1);
    step();
`ifdef ILLEGAL_OPCODE_TRAP_EN
    chk("halt_state", State, 12); chk("halt_flag", Halted, 1);
    chk("halt_memread", MemRead, 0); chk("halt_pcwrite", PCWrite, 0);
    chk("halt_irwrite", IRWrite, 0);
    Opcode = 6'b000000;
    step(); step();
    chk("halt_stays", State, 12); chk("halt_count", InstrCount, 0);
`else
    chk("ill_fetch", State, 0); chk("ill_count", InstrCount, 0);
    Opcode = 6'b000000;
    step(); step(); step(); step();
    chk("ill_resume_count", InstrCount, 1);
`endif

    // reset mid-lw in MEMREAD
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst2_state", State, 0);
    chk("rst2_count", InstrCount, 0);
    Opcode = 6'b001000;
    step(); step(); step(); step();
    chk("pre_count", InstrCount, 1);
    Opcode = 6'b100011;
    step(); step(); step(); chk("mid_s3", State, 3);
    Reset = 1'b1;
    step();
    chk("mid_rst_state", State, 0); chk("mid_rst_count", InstrCount, 0);
    chk("mid_rst_regwrite", RegWrite, 0);
    Reset = 1'b0;
    step();
    chk("post_rst_state", State, 1); chk("post_rst_regwrite", RegWrite, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
